// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state encoding, width helper and defaults for the wishbone master arbiter
package wb_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wishbone_master_arbiter_picker.sv
// rtl/wishbone_master_arbiter_picker.sv - combinational round-robin winner select (wb_rr_picker)
module wb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       winner,
    output logic                   any_req
);

    logic found;

    // First pass covers indices above the last-served one, second pass wraps around.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        any_req = |req;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req[k] && (k > int'(rr_ptr))) begin
                found  = 1'b1;
                winner = IDX_W'(k);
            end
        end
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req[k] && (k <= int'(rr_ptr))) begin
                found  = 1'b1;
                winner = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/wishbone_master_arbiter.sv
// rtl/wishbone_master_arbiter.sv - N-to-1 round-robin Wishbone Classic arbiter, grant held per CYC
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    input  logic [NUM_MASTERS-1:0]            m_wb_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_wb_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_wb_we_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_wb_sel_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_wb_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wb_dat_i,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wb_dat_o,
    output logic [NUM_MASTERS-1:0]            m_wb_ack_o,
    output logic [NUM_MASTERS-1:0]            m_wb_err_o,
    output logic                              s_wb_cyc_o,
    output logic                              s_wb_stb_o,
    output logic                              s_wb_we_o,
    output logic [SEL_WIDTH-1:0]              s_wb_sel_o,
    output logic [ADDR_WIDTH-1:0]             s_wb_adr_o,
    output logic [DATA_WIDTH-1:0]             s_wb_dat_o,
    input  logic [DATA_WIDTH-1:0]             s_wb_dat_i,
    input  logic                              s_wb_ack_i,
    input  logic                              s_wb_err_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int IDX_W = (clog2(NUM_MASTERS) < 1) ? 1 : clog2(NUM_MASTERS);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] req;
    logic [IDX_W-1:0]       winner;
    logic                   any_req;
    logic                   grant_valid;
    logic                   g_cyc, g_stb;
    logic                   timeout_hit;

    assign req         = m_wb_cyc_i & m_wb_stb_i;
    assign grant_valid = (state_q == ST_BUSY);

    wb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // Everything forwarded downstream is zero unless a grant is held.
    always_comb begin
        g_cyc      = 1'b0;
        g_stb      = 1'b0;
        s_wb_we_o  = 1'b0;
        s_wb_sel_o = '0;
        s_wb_adr_o = '0;
        s_wb_dat_o = '0;
        grant_o    = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_valid && (gnt_idx_q == IDX_W'(k))) begin
                g_cyc      = m_wb_cyc_i[k];
                g_stb      = m_wb_stb_i[k];
                s_wb_we_o  = m_wb_we_i[k];
                s_wb_sel_o = m_wb_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
                s_wb_adr_o = m_wb_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                s_wb_dat_o = m_wb_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                grant_o[k] = 1'b1;
            end
        end
    end

    assign s_wb_cyc_o = g_cyc & ~timeout_hit;
    assign s_wb_stb_o = g_stb & ~timeout_hit;
    assign m_wb_ack_o = grant_o & {NUM_MASTERS{s_wb_ack_i}};
    assign m_wb_err_o = grant_o & {NUM_MASTERS{s_wb_err_i | timeout_hit}};
    assign m_wb_dat_o = {NUM_MASTERS{s_wb_dat_i}};

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d   = ST_BUSY;
                    gnt_idx_d = winner;
                    rr_ptr_d  = winner;
                end
            end
            ST_BUSY: begin
                if (!g_cyc || timeout_hit) begin
                    state_d   = ST_IDLE;
                    gnt_idx_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            gnt_idx_q <= '0;
            rr_ptr_q  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Count stalled strobe cycles; the hit cycle itself is the TIMEOUT_CYCLES-th stall.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        timeout_hit = 1'b0;
        if (!grant_valid || !g_cyc || s_wb_ack_i || s_wb_err_i) begin
            tmo_cnt_d = '0;
        end else if (g_stb) begin
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
                tmo_cnt_d   = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// tb/tb_wishbone_master_arbiter.sv - self-checking bench for wishbone_master_arbiter
module tb_wishbone_master_arbiter;

    localparam int NM  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cyc_r[NM], stb_r[NM], we_r[NM];
    logic [AW-1:0] adr_r[NM];
    logic [DW-1:0] dat_r[NM];
    logic [SW-1:0] sel_r[NM];

    logic [NM-1:0]    m_cyc, m_stb, m_we;
    logic [NM*SW-1:0] m_sel;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat;
    logic [NM*DW-1:0] m_dat_o;
    logic [NM-1:0]    m_ack, m_err, grant;
    logic             s_cyc, s_stb, s_we;
    logic [SW-1:0]    s_sel;
    logic [AW-1:0]    s_adr;
    logic [DW-1:0]    s_dat_o;
    logic [DW-1:0]    s_dat = '0;
    logic             s_ack = 1'b0;
    logic             s_err = 1'b0;

    always_comb begin
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
        for (int k = 0; k < NM; k++) begin
            m_cyc[k]          = cyc_r[k];
            m_stb[k]          = stb_r[k];
            m_we[k]           = we_r[k];
            m_sel[k*SW +: SW] = sel_r[k];
            m_adr[k*AW +: AW] = adr_r[k];
            m_dat[k*DW +: DW] = dat_r[k];
        end
    end

    wishbone_master_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we),
        .m_wb_sel_i(m_sel), .m_wb_adr_i(m_adr), .m_wb_dat_i(m_dat),
        .m_wb_dat_o(m_dat_o), .m_wb_ack_o(m_ack), .m_wb_err_o(m_err),
        .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
        .s_wb_sel_o(s_sel), .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dat_o),
        .s_wb_dat_i(s_dat), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
        .grant_o(grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner of the bus (-1 = none), last master served, stalled strobe count.
    int own   = -1;
    int last  = NM - 1;
    int stall = 0;

    function automatic int pick(input logic [NM-1:0] req, input int from);
        int c;
        for (int j = 1; j <= NM; j++) begin
            c = (from + j) % NM;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit tmo_now();
`ifdef WB_ARB_TIMEOUT_EN
        return (own >= 0) && m_cyc[own] && m_stb[own] && !s_ack && !s_err && (stall == TMO - 1);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            own <= -1; last <= NM - 1; stall <= 0;
        end else if (own < 0) begin
            if ((m_cyc & m_stb) != '0) begin
                own  <= pick(m_cyc & m_stb, last);
                last <= pick(m_cyc & m_stb, last);
            end
            stall <= 0;
        end else if (!m_cyc[own] || tmo_now()) begin
            own <= -1; stall <= 0;
        end else if (s_ack || s_err) begin
            stall <= 0;
        end else if (m_stb[own]) begin
            stall <= stall + 1;
        end
    end

    task automatic compare();
        logic e_cyc, e_stb, e_we;
        logic [SW-1:0] e_sel;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [NM-1:0] e_g, e_ack, e_err;
        bit t;
        e_cyc = 0; e_stb = 0; e_we = 0; e_sel = '0; e_adr = '0; e_dat = '0;
        e_g = '0; e_ack = '0; e_err = '0;
        if (own >= 0) begin
            t        = tmo_now();
            e_cyc    = m_cyc[own] & !t;
            e_stb    = m_stb[own] & !t;
            e_we     = m_we[own];
            e_sel    = sel_r[own];
            e_adr    = adr_r[own];
            e_dat    = dat_r[own];
            e_g[own] = 1'b1;
            e_ack[own] = s_ack;
            e_err[own] = s_err | t;
        end
        chk("cyc", s_cyc, e_cyc);
        chk("stb", s_stb, e_stb);
        chk("we", s_we, e_we);
        chk("sel", s_sel, e_sel);
        chk("adr", s_adr, e_adr);
        chk("wdat", s_dat_o, e_dat);
        chk("grant", grant, e_g);
        chk("ack", m_ack, e_ack);
        chk("err", m_err, e_err);
        chk("rdat", m_dat_o, {NM{s_dat}});
    endtask

    initial forever begin
        @(negedge clk);
        compare();
    end

    // Grant log, response counters.
    int          glog[$];
    logic [NM-1:0] prev_g = '0;
    int          ack_cnt[NM];
    int          err_cnt[NM];
    logic [NM-1:0] last_err_vec = '0;

    initial begin
        for (int k = 0; k < NM; k++) begin ack_cnt[k] = 0; err_cnt[k] = 0; end
        forever begin
            @(negedge clk);
            if (grant != '0 && prev_g == '0) begin
                for (int k = 0; k < NM; k++) if (grant[k]) glog.push_back(k);
            end
            prev_g = grant;
            if (m_err != '0) last_err_vec = m_err;
            for (int k = 0; k < NM; k++) begin
                ack_cnt[k] += int'(m_ack[k]);
                err_cnt[k] += int'(m_err[k]);
            end
        end
    end

    // Slave: answers one cycle into each strobe, one response per cycle at most.
    bit        slave_on = 1'b1, slave_err = 1'b0, slave_force = 1'b0;
    logic [DW-1:0] rd_q[$];
    int        nresp = 0;

    initial forever begin
        @(posedge clk);
        #2;
        if (slave_force) begin
            s_ack = 1'b1;
        end else if (!s_ack && !s_err && s_stb && slave_on) begin
            if (slave_err) s_err = 1'b1; else s_ack = 1'b1;
            if (rd_q.size() > 0) s_dat = rd_q.pop_front();
            else s_dat = 32'hC0DE_0000 + nresp;
            nresp++;
        end else begin
            s_ack = 1'b0;
            s_err = 1'b0;
        end
    end

    logic [DW-1:0] rx1_q[$];

    task automatic master_burst(input int m, input int nb, input logic w,
                                input logic [31:0] a, input logic [31:0] d);
        int  t;
        bit  got;
        @(posedge clk); #1;
        cyc_r[m] = 1'b1; stb_r[m] = 1'b1; we_r[m] = w; adr_r[m] = a; dat_r[m] = d; sel_r[m] = 4'hF;
        for (int b = 0; b < nb; b++) begin
            t = 0; got = 1'b0;
            while (!got && t < 200) begin
                @(negedge clk);
                t++;
                if (m_ack[m] || m_err[m]) begin
                    got = 1'b1;
                    if (m_ack[m] && m == 1) rx1_q.push_back(m_dat_o[m*DW +: DW]);
                end
            end
            chk("ack_wait", got, 1'b1);
            @(posedge clk); #1;
            adr_r[m] = a + 32'(4 * (b + 1));
            dat_r[m] = d + 32'(b + 1);
            if (b == nb - 1) begin cyc_r[m] = 1'b0; stb_r[m] = 1'b0; end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal;
    end

    int a0, e0, e1;

    initial begin
        for (int k = 0; k < NM; k++) begin
            cyc_r[k] = 0; stb_r[k] = 0; we_r[k] = 0;
            adr_r[k] = 32'hFFFF_FFF0 + k; dat_r[k] = 32'hA5A5_0000 + k; sel_r[k] = 4'hF;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", s_cyc, 0);
        chk("rst_stb", s_stb, 0);
        chk("rst_grant", grant, 0);
        chk("rst_adr", s_adr, 0);
        chk("rst_ack", m_ack, 0);
        @(posedge clk); #1 rst = 1'b0;

        // single write from master 0
        @(posedge clk); #1;
        cyc_r[0] = 1; stb_r[0] = 1; we_r[0] = 1; adr_r[0] = 32'h0001_0004; dat_r[0] = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_stb_before", s_stb, 0);
        @(negedge clk);
        chk("t1_stb", s_stb, 1);
        chk("t1_adr", s_adr, 32'h0001_0004);
        chk("t1_dat", s_dat_o, 32'hDEADBEEF);
        chk("t1_we", s_we, 1);
        chk("t1_ack", m_ack, 2'b01);
        @(posedge clk); #1;
        cyc_r[0] = 0; stb_r[0] = 0;
        @(negedge clk);
        chk("t1_cyc_drop", s_cyc, 0);
        chk("t1_grant_held", grant, 2'b01);
        @(negedge clk);
        chk("t1_grant_clear", grant, 0);

        // simultaneous requests alternate from a fresh reset
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        glog.delete();
        fork
            begin for (int i0 = 0; i0 < 5; i0++) master_burst(0, 1, 1, 32'h100 + 4 * i0, i0); end
            begin for (int i1 = 0; i1 < 5; i1++) master_burst(1, 1, 1, 32'h200 + 4 * i1, i1); end
        join
        chk("t2_ngrants", glog.size(), 10);
        for (int i = 0; i < glog.size() && i < 10; i++) chk("t2_order", glog[i], i % 2);

        // master 1 burst is not preempted
        glog.delete(); rx1_q.delete();
        rd_q = {32'h11, 32'h22, 32'h33, 32'h44};
        fork
            master_burst(1, 4, 0, 32'h2000, 0);
            begin repeat (2) @(posedge clk); master_burst(0, 1, 1, 32'h3000, 32'h55); end
        join
        chk("t3_ngrants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t3_first", glog[0], 1);
            chk("t3_second", glog[1], 0);
        end
        chk("t3_nwords", rx1_q.size(), 4);
        if (rx1_q.size() == 4) begin
            chk("t3_w0", rx1_q[0], 32'h11);
            chk("t3_w1", rx1_q[1], 32'h22);
            chk("t3_w2", rx1_q[2], 32'h33);
            chk("t3_w3", rx1_q[3], 32'h44);
        end

        // downstream error
        a0 = ack_cnt[0]; e0 = err_cnt[0]; e1 = err_cnt[1];
        last_err_vec = '0;
        slave_err = 1'b1;
        master_burst(0, 1, 0, 32'h4000, 0);
        slave_err = 1'b0;
        repeat (2) @(posedge clk);
        chk("t4_err0", err_cnt[0] - e0, 1);
        chk("t4_err1", err_cnt[1] - e1, 0);
        chk("t4_ack0", ack_cnt[0] - a0, 0);
        chk("t4_errvec", last_err_vec, 2'b01);

        // response while idle is dropped
        @(posedge clk); #1 slave_force = 1'b1;
        @(negedge clk);
        chk("t5_idle_ack", m_ack, 0);
        chk("t5_idle_grant", grant, 0);
        @(posedge clk); #1 slave_force = 1'b0;

        // async reset mid-transfer restores master 0 priority
        slave_on = 1'b0;
        @(posedge clk); #1;
        cyc_r[0] = 1; stb_r[0] = 1; we_r[0] = 0; adr_r[0] = 32'h5000;
        repeat (3) @(posedge clk);
        #3;
        chk("t6_busy", s_cyc, 1);
        rst = 1'b1;
        #1;
        chk("t6_cyc_async", s_cyc, 0);
        chk("t6_stb_async", s_stb, 0);
        chk("t6_grant_async", grant, 0);
        cyc_r[0] = 0; stb_r[0] = 0; slave_on = 1'b1;
        #2 rst = 1'b0;
        glog.delete();
        fork
            master_burst(0, 1, 1, 32'h6000, 32'h1);
            master_burst(1, 1, 1, 32'h7000, 32'h2);
        join
        chk("t6_ngrants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t6_first", glog[0], 0);
            chk("t6_second", glog[1], 1);
        end

`ifdef WB_ARB_TIMEOUT_EN
        begin
            int  n;
            bit  found;
            n = -1; found = 1'b0;
            slave_on = 1'b0;
            @(posedge clk); #1;
            cyc_r[0] = 1; stb_r[0] = 1; we_r[0] = 0; adr_r[0] = 32'h8000;
            for (int c = 1; c <= 30 && !found; c++) begin
                @(negedge clk);
                if (m_err[0]) begin
                    found = 1'b1;
                    n = c - 1;
                    chk("t7_cyc_forced", s_cyc, 0);
                    chk("t7_errvec", m_err, 2'b01);
                end
            end
            chk("t7_found", found, 1'b1);
            chk("t7_cycle", n, TMO);
            @(negedge clk);
            chk("t7_idle", grant, 0);
            @(posedge clk); #1;
            cyc_r[0] = 0; stb_r[0] = 0; slave_on = 1'b1;
        end
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_master_arbiter.md
Name: wishbone_master_arbiter

Overview:
- N-to-1 Wishbone Classic arbiter that shares one downstream Wishbone port between several bus masters (e.g. CPU plus DMA engines).
- The downstream port feeds the peripheral bus splitter.
- Round-robin fairness; a grant is held for the whole CYC bus cycle, so multi-beat and locked transfers stay atomic.
- Grant is registered: one-cycle arbitration latency.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>= 2).
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width.
- SEL_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT_CYCLES, 255, watchdog limit in clocks; used only with the optional feature; must be >= 2.

Ports:
- wb_clk_i  in  1  system clock; all state changes on its rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- m_wb_cyc_i  in  NUM_MASTERS  per-master CYC.
- m_wb_stb_i  in  NUM_MASTERS  per-master STB.
- m_wb_we_i  in  NUM_MASTERS  per-master WE.
- m_wb_sel_i  in  NUM_MASTERS*SEL_WIDTH  flattened byte selects; master k at [k*SEL_WIDTH +: SEL_WIDTH].
- m_wb_adr_i  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses.
- m_wb_dat_i  in  NUM_MASTERS*DATA_WIDTH  flattened write data.
- m_wb_dat_o  out  NUM_MASTERS*DATA_WIDTH  read data; downstream data broadcast to every slot.
- m_wb_ack_o  out  NUM_MASTERS  per-master ACK.
- m_wb_err_o  out  NUM_MASTERS  per-master ERR.
- s_wb_cyc_o  out  1  downstream CYC.
- s_wb_stb_o  out  1  downstream STB.
- s_wb_we_o  out  1  downstream WE.
- s_wb_sel_o  out  SEL_WIDTH  downstream byte select.
- s_wb_adr_o  out  ADDR_WIDTH  downstream address.
- s_wb_dat_o  out  DATA_WIDTH  downstream write data.
- s_wb_dat_i  in  DATA_WIDTH  downstream read data.
- s_wb_ack_i  in  1  downstream ACK.
- s_wb_err_i  in  1  downstream ERR.
- grant_o  out  NUM_MASTERS  one-hot current grant; all zero in IDLE. Status/debug.

Behaviour:
- States: IDLE, BUSY. Registers: state, grant index gnt_idx, grant_valid, last-served pointer rr_ptr.
- Reset (async): state=IDLE, grant_o=0, rr_ptr=NUM_MASTERS-1, so master 0 has first priority.
  - All downstream control outputs 0 (cyc, stb, we).
  - All m_wb_ack_o and m_wb_err_o are 0.
  - Address, data and sel outputs are 0 while no grant is held.
- Request from master k = m_wb_cyc_i[k] & m_wb_stb_i[k].
- IDLE, any request present:
  - Choose the first requester scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_MASTERS.
  - Next edge: gnt_idx=winner, rr_ptr=winner, state=BUSY.
- IDLE, no request: remain; downstream cyc/stb = 0.
- BUSY, forwarding:
  - s_wb_cyc_o = m_wb_cyc_i[gnt_idx]; s_wb_stb_o = m_wb_stb_i[gnt_idx].
  - we/sel/adr/dat are passed through combinationally from the granted master.
- BUSY, responses:
  - m_wb_ack_o[gnt_idx] = s_wb_ack_i; m_wb_err_o[gnt_idx] = s_wb_err_i (combinational).
  - ACK/ERR of all non-granted masters are forced 0.
- Release: in BUSY, when m_wb_cyc_i[gnt_idx]==0 at an edge, go to IDLE and clear grant.
  - Re-arbitration happens on the following edge.
  - Minimum one idle cycle between grants; downstream CYC low for that cycle.
- The grant persists across multiple STB beats while CYC stays high (no preemption).
- Latency: request to downstream STB is 1 clock; downstream ACK to master ACK is 0 clocks.
- Simultaneous requests: round-robin order strictly from rr_ptr+1.
- A master dropping its request while still IDLE (before being granted) is simply not chosen.
- Reset asserted mid-transfer: the grant is dropped immediately (async); downstream CYC/STB go low in the same instant.
- ACK/ERR arriving from downstream while IDLE: ignored, not forwarded.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter counts clocks in BUSY while s_wb_stb_o=1 and s_wb_ack_i|s_wb_err_i=0.
  - The counter clears on ACK/ERR, on release and on reset.
  - When it reaches TIMEOUT_CYCLES: assert m_wb_err_o[gnt_idx] for exactly one cycle, force s_wb_cyc_o/s_wb_stb_o to 0 that cycle, then go to IDLE.
  - A late downstream ACK after the timeout is ignored.
- Not defined: no counter; a hung slave holds the grant indefinitely.

Decomposition:
- Shared package wb_arb_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1;
  - a clog2 helper function;
  - the default TIMEOUT_CYCLES value.
- One sub-module, wb_rr_picker:
  - combinational; inputs request vector and rr_ptr;
  - outputs winner index and any_req.

Test Plan:
- Reset, then master 0 single write adr=0x0001_0004 dat=0xDEADBEEF -> s_wb_stb_o rises 1 clock after request; slave ACK gives m_wb_ack_o=2'b01 in the same cycle; grant_o returns to 0 one clock after CYC drops.
- Masters 0 and 1 request in the same cycle, repeatedly (5 single-beat transfers each) -> grants alternate 0,1,0,1…; neither master waits more than one other transfer.
- Master 1 holds CYC for 4 read beats (slave returns 0x11,0x22,0x33,0x44) while master 0 requests -> master 0 gets no grant until master 1 drops CYC; master 1 receives all 4 words in order.
- Downstream ERR on a master 0 read -> m_wb_err_o=2'b01 for one cycle, m_wb_ack_o stays 0, master 1 sees nothing.
- wb_rst_i pulsed asynchronously mid-BUSY (between clock edges) -> s_wb_cyc_o and grant_o go 0 immediately; after release master 0 has priority.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> m_wb_err_o of the granted master pulses in cycle 8 after STB; s_wb_cyc_o drops; arbiter returns to IDLE.
